// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared constants for the NES pad emulator
package nes_pkg;

    // Serial order of the buttons on the data line (bit 0 leaves first)
    localparam int NES_BTN_A      = 0;
    localparam int NES_BTN_B      = 1;
    localparam int NES_BTN_SELECT = 2;
    localparam int NES_BTN_START  = 3;
    localparam int NES_BTN_UP     = 4;
    localparam int NES_BTN_DOWN   = 5;
    localparam int NES_BTN_LEFT   = 6;
    localparam int NES_BTN_RIGHT  = 7;

    localparam int NES_BITS = 8;

    // Frame state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Data line level when no button is reported (active-low line)
    localparam logic NES_IDLE_LEVEL = 1'b1;

    // Buttons are pressed=1 internally but travel active-low on the wire
    function automatic logic [NES_BITS-1:0] pad_word(input logic [NES_BITS-1:0] pressed);
        return ~pressed;
    endfunction

endpackage

// File: rtl/nes_pin_filter.sv
// rtl/nes_pin_filter.sv - synchroniser, glitch filter and edge strobes for one host pin
module nes_pin_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       sync0;
    logic       sync1;
    logic [3:0] count;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= pin;
            sync1 <= sync0;
        end
    end

    // Accept a new level only after it has been stable for FILTER_LEN cycles; emit one-cycle strobes on change
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b0;
            count <= 4'd0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync1 != level) begin
                if (count == 4'(FILTER_LEN - 1)) begin
                    level <= sync1;
                    count <= 4'd0;
                    rise  <= sync1;
                    fall  <= ~sync1;
                end else begin
                    count <= count + 4'd1;
                end
            end else begin
                count <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/nes_pad_emulator.sv
// rtl/nes_pad_emulator.sv - NES controller side: latch buttons, shift them out active-low
module nes_pad_emulator
    import nes_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       latch_in,
    input  logic       nes_clk_in,
    input  logic [7:0] buttons,
    output logic       data_out,
    output logic       frame_done,
    output logic       host_active,
    output logic [3:0] bit_idx
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    logic            latch_level;
    logic            latch_rise;
    logic            latch_fall;
    logic            clk_level;
    logic            clk_rise;
    logic            clk_fall;
    logic [1:0]      state;
    logic [7:0]      shift_reg;
    logic [WD_W-1:0] wd_count;

    nes_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_latch_filter (
        .clk   (clk),
        .reset (reset),
        .pin   (latch_in),
        .level (latch_level),
        .rise  (latch_rise),
        .fall  (latch_fall)
    );

    nes_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .pin   (nes_clk_in),
        .level (clk_level),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    // Filtered levels and the nes_clk falling edge carry no meaning here: the host samples while nes_clk is high
    logic unused_pins;
    assign unused_pins = &{1'b0, latch_level, clk_level, clk_fall};

    // Frame sequencer: a latch rise always restarts the frame, even on top of a shift-clock edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift_reg  <= 8'hFF;
            bit_idx    <= 4'd0;
            data_out   <= NES_IDLE_LEVEL;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (latch_rise) begin
                state     <= ST_LOAD;
                shift_reg <= pad_word(buttons);
                bit_idx   <= 4'd0;
                data_out  <= ~buttons[NES_BTN_A];
            end else begin
                case (state)
                    ST_IDLE: begin
                        data_out <= NES_IDLE_LEVEL;
                    end
                    ST_LOAD: begin
                        shift_reg <= pad_word(buttons);
                        bit_idx   <= 4'd0;
                        data_out  <= ~buttons[NES_BTN_A];
                        if (latch_fall) begin
                            state <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (clk_rise) begin
                            shift_reg <= {NES_IDLE_LEVEL, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 4'd1;
                            if (bit_idx == 4'(NES_BITS - 1)) begin
                                data_out   <= NES_IDLE_LEVEL;
                                frame_done <= 1'b1;
                                state      <= ST_DONE;
                            end else begin
                                data_out <= shift_reg[1];
                            end
                        end
                    end
                    default: begin
                        data_out <= NES_IDLE_LEVEL;
                    end
                endcase
            end
        end
    end

    // Watchdog: host_active stays high for TIMEOUT_CYCLES cycles after each accepted latch rise
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_count    <= '0;
            host_active <= 1'b0;
        end else if (latch_rise) begin
            wd_count    <= '0;
            host_active <= 1'b1;
        end else if (wd_count != WD_MAX) begin
            wd_count <= wd_count + 1'b1;
            if (wd_count == WD_MAX - 1'b1) begin
                host_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nes_pad_emulator.sv
// tb/tb_nes_pad_emulator.sv - self-checking bench for nes_pad_emulator
module tb_nes_pad_emulator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       latch_in = 1'b0;
    logic       nes_clk_in = 1'b0;
    logic [7:0] buttons = 8'h00;

    logic       data_out, frame_done, host_active;
    logic [3:0] bit_idx;
    logic       wd_data_out, wd_frame_done, wd_host_active;
    logic [3:0] wd_bit_idx;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    bit toggle_en = 1'b0;

    nes_pad_emulator #(.FILTER_LEN(4), .TIMEOUT_CYCLES(2000000)) dut (
        .clk(clk), .reset(reset), .latch_in(latch_in), .nes_clk_in(nes_clk_in),
        .buttons(buttons), .data_out(data_out), .frame_done(frame_done),
        .host_active(host_active), .bit_idx(bit_idx)
    );

    nes_pad_emulator #(.FILTER_LEN(4), .TIMEOUT_CYCLES(100)) dut_wd (
        .clk(clk), .reset(reset), .latch_in(latch_in), .nes_clk_in(nes_clk_in),
        .buttons(buttons), .data_out(wd_data_out), .frame_done(wd_frame_done),
        .host_active(wd_host_active), .bit_idx(wd_bit_idx)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (toggle_en) buttons = buttons ^ 8'($urandom_range(1, 255));
        end
    endtask

    // Host-side frame: latch, read bit 0, then 8+extra shift pulses; seen[k] is data_out sampled after pulse k
    task automatic read_frame(input int lat, input int hi, input int lo, input int extra,
                              input bit tog, output logic [8:0] seen);
        latch_in = 1'b1;
        cyc(lat);
        latch_in = 1'b0;
        cyc(lo);
        seen[0] = data_out;
        toggle_en = tog;
        for (int k = 1; k <= 8 + extra; k++) begin
            nes_clk_in = 1'b1;
            cyc(hi);
            if (k <= 8) seen[k] = data_out;
            nes_clk_in = 1'b0;
            cyc(lo);
        end
        toggle_en = 1'b0;
    endtask

    // Reference: the pad reports each pressed button as 0, in A..right order, then idles high
    function automatic logic [8:0] expect_frame(input logic [7:0] pressed);
        logic [8:0] e;
        for (int k = 0; k < 9; k++) e[k] = (k < 8) ? !pressed[k] : 1'b1;
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        cyc(3);
        checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL reset_data_out got %b want 1", data_out); end
        checks++; if (host_active !== 1'b0) begin errors++; $display("FAIL reset_host_active got %b want 0", host_active); end
        checks++; if (bit_idx !== 4'd0) begin errors++; $display("FAIL reset_bit_idx got %0d want 0", bit_idx); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        reset = 1'b0;
        cyc(5);
        checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL idle_data_out got %b want 1", data_out); end
    endtask

    task automatic test_host_frame();
        logic [8:0] seen;
        int fd0;
        buttons = 8'h81;
        fd0 = fd_cnt;
        read_frame(600, 300, 300, 0, 1'b0, seen);
        checks++; if (seen[7:0] !== 8'h7E) begin errors++; $display("FAIL host_frame_bits got %b want %b", seen[7:0], 8'h7E); end
        checks++; if (seen[8] !== 1'b1 || data_out !== 1'b1) begin errors++; $display("FAIL host_frame_past_end got %b/%b want 1/1", seen[8], data_out); end
        checks++; if (bit_idx !== 4'd8) begin errors++; $display("FAIL host_frame_bit_idx got %0d want 8", bit_idx); end
        checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL host_frame_done got %0d pulses want 1", fd_cnt - fd0); end
        checks++; if (host_active !== 1'b1) begin errors++; $display("FAIL host_frame_active got %b want 1", host_active); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] seen;
        logic [7:0] btn;
        int fd0;
        for (int n = 0; n < 5; n++) begin
            btn = 8'($urandom);
            buttons = btn;
            fd0 = fd_cnt;
            read_frame($urandom_range(10, 30), $urandom_range(8, 20), $urandom_range(8, 20), 0, 1'b0, seen);
            checks++; if (seen !== expect_frame(btn)) begin errors++; $display("FAIL b2b_frame_%0d got %b want %b (buttons %h)", n, seen, expect_frame(btn), btn); end
            checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL b2b_done_%0d got %0d pulses want 1", n, fd_cnt - fd0); end
        end
    endtask

    task automatic test_glitch();
        logic [8:0] e;
        logic [7:0] btn;
        btn = 8'($urandom);
        buttons = btn;
        e = expect_frame(btn);
        latch_in = 1'b1; cyc(20); latch_in = 1'b0; cyc(12);
        for (int k = 0; k < 2; k++) begin
            nes_clk_in = 1'b1; cyc(10); nes_clk_in = 1'b0; cyc(10);
        end
        nes_clk_in = 1'b1; cyc(2); nes_clk_in = 1'b0; cyc(20);
        checks++; if (bit_idx !== 4'd2) begin errors++; $display("FAIL glitch_bit_idx got %0d want 2", bit_idx); end
        checks++; if (data_out !== e[2]) begin errors++; $display("FAIL glitch_data_out got %b want %b", data_out, e[2]); end
        nes_clk_in = 1'b1; cyc(5); nes_clk_in = 1'b0; cyc(20);
        checks++; if (bit_idx !== 4'd3) begin errors++; $display("FAIL pulse5_bit_idx got %0d want 3", bit_idx); end
        checks++; if (data_out !== e[3]) begin errors++; $display("FAIL pulse5_data_out got %b want %b", data_out, e[3]); end
    endtask

    task automatic test_abort();
        logic [8:0] seen;
        int fd0;
        buttons = 8'($urandom);
        fd0 = fd_cnt;
        latch_in = 1'b1; cyc(20); latch_in = 1'b0; cyc(12);
        for (int k = 0; k < 3; k++) begin
            nes_clk_in = 1'b1; cyc(10); nes_clk_in = 1'b0; cyc(10);
        end
        checks++; if (bit_idx !== 4'd3) begin errors++; $display("FAIL abort_pre_bit_idx got %0d want 3", bit_idx); end
        buttons = 8'h02;
        latch_in = 1'b1; cyc(20);
        checks++; if (bit_idx !== 4'd0) begin errors++; $display("FAIL abort_bit_idx got %0d want 0", bit_idx); end
        checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL abort_data_out got %b want 1", data_out); end
        checks++; if (fd_cnt - fd0 !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", fd_cnt - fd0); end
        latch_in = 1'b0;
        read_frame(10, 10, 10, 0, 1'b0, seen);
        checks++; if (seen[7:0] !== 8'b1111_1101) begin errors++; $display("FAIL abort_frame got %b want 11111101", seen[7:0]); end
        checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL abort_done_count got %0d pulses want 1", fd_cnt - fd0); end
    endtask

    task automatic test_button_toggle();
        logic [8:0] seen;
        logic [7:0] btn;
        int fd0;
        for (int n = 0; n < 2; n++) begin
            btn = 8'($urandom);
            buttons = btn;
            fd0 = fd_cnt;
            read_frame(15, $urandom_range(8, 14), $urandom_range(10, 14), 4, 1'b1, seen);
            checks++; if (seen !== expect_frame(btn)) begin errors++; $display("FAIL toggle_frame_%0d got %b want %b", n, seen, expect_frame(btn)); end
            checks++; if (data_out !== 1'b1 || bit_idx !== 4'd8) begin errors++; $display("FAIL toggle_extra_%0d got data %b idx %0d want 1/8", n, data_out, bit_idx); end
            checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL toggle_done_%0d got %0d pulses want 1", n, fd_cnt - fd0); end
        end
    endtask

    task automatic test_reset_mid_frame();
        buttons = 8'h00;
        latch_in = 1'b1; cyc(20); latch_in = 1'b0; cyc(12);
        for (int k = 0; k < 3; k++) begin
            nes_clk_in = 1'b1; cyc(10); nes_clk_in = 1'b0; cyc(10);
        end
        reset = 1'b1;
        cyc(1);
        checks++; if (data_out !== 1'b1 || bit_idx !== 4'd0 || host_active !== 1'b0 || frame_done !== 1'b0)
        begin errors++; $display("FAIL mid_reset got data %b idx %0d act %b done %b want 1/0/0/0", data_out, bit_idx, host_active, frame_done); end
        cyc(1);
        reset = 1'b0;
        cyc(20);
        checks++; if (data_out !== 1'b1 || bit_idx !== 4'd0) begin errors++; $display("FAIL post_reset_idle got data %b idx %0d want 1/0", data_out, bit_idx); end
    endtask

    task automatic test_watchdog();
        int wait_n;
        int high_n;
        logic [7:0] btn;
        btn = 8'($urandom);
        buttons = btn;
        cyc(150);
        checks++; if (wd_host_active !== 1'b0) begin errors++; $display("FAIL wd_idle got %b want 0", wd_host_active); end
        latch_in = 1'b1;
        wait_n = 0;
        while (wd_host_active !== 1'b1 && wait_n < 50) begin cyc(1); wait_n++; end
        checks++; if (wd_host_active !== 1'b1) begin errors++; $display("FAIL wd_rise got %b want 1 within 50 cycles", wd_host_active); end
        cyc(10);
        latch_in = 1'b0;
        high_n = 10;
        while (wd_host_active === 1'b1 && high_n < 300) begin cyc(1); high_n++; end
        checks++; if (high_n !== 100) begin errors++; $display("FAIL wd_high_cycles got %0d want 100", high_n); end
        checks++; if (wd_data_out !== !btn[0]) begin errors++; $display("FAIL wd_data_kept got %b want %b", wd_data_out, !btn[0]); end
        latch_in = 1'b1;
        wait_n = 0;
        while (wd_host_active !== 1'b1 && wait_n < 50) begin cyc(1); wait_n++; end
        checks++; if (wd_host_active !== 1'b1) begin errors++; $display("FAIL wd_rearm got %b want 1 within 50 cycles", wd_host_active); end
        latch_in = 1'b0;
        cyc(20);
    endtask

    initial begin
        test_reset();
        test_host_frame();
        test_back_to_back();
        test_glitch();
        test_abort();
        test_button_toggle();
        test_reset_mid_frame();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
